count_down_m100: RTL and testbench

COUNT_DOWN_M100 -- requirements
Module: count_down_m100

---
 rtl/count_down_m100.sv | 162 ++++++++++++++++
 tb/tb_count_down_m100.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/count_down_m100.sv
// Two-digit BCD down-counter with prescaled steps, pause, and done/error pulses.
// Optional auto-reload on reaching 00 is enabled by defining COUNT_DOWN_AUTORELOAD_EN.
module count_down_m100 #(
   parameter int STEP_DIV = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       pause,
   input  logic [7:0] load_value,
   output logic [3:0] counter_value,
   output logic [3:0] tens_value,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [1:0] o_dbg_state
);

   // Handshake: none; start/pause are level inputs sampled on every rising edge,
   // done/error are single-cycle registered pulses.
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSED, ST_DONE} state_t;

   localparam logic [7:0] LP_LAST = 8'(STEP_DIV - 1);

   state_t     r_state;
   logic [3:0] r_units;
   logic [3:0] r_tens;
   logic [7:0] r_presc;
   logic       r_done;
   logic       r_error;

   state_t     w_state_nx;
   logic [3:0] w_units_nx;
   logic [3:0] w_tens_nx;
   logic [7:0] w_presc_nx;
   logic       w_done_nx;
   logic       w_error_nx;
   logic [3:0] w_step_units;
   logic [3:0] w_step_tens;
   logic       w_step_zero;
   logic       w_ld_bad;
   logic       w_ld_zero;

`ifdef COUNT_DOWN_AUTORELOAD_EN
   logic [7:0] r_reload;
   logic [7:0] w_reload_nx;
`endif

   assign w_ld_bad  = (load_value[3:0] > 4'd9) || (load_value[7:4] > 4'd9);
   assign w_ld_zero = (load_value == 8'h00);

   // Value after one decrement step; BCD borrow from tens when units is 0.
   always_comb begin
      w_step_units = r_units;
      w_step_tens  = r_tens;
`ifdef COUNT_DOWN_AUTORELOAD_EN
      if ((r_units == 4'd0) && (r_tens == 4'd0)) begin
         w_step_units = r_reload[3:0];
         w_step_tens  = r_reload[7:4];
      end else
`endif
      if (r_units != 4'd0) begin
         w_step_units = r_units - 4'd1;
      end else if (r_tens != 4'd0) begin
         w_step_units = 4'd9;
         w_step_tens  = r_tens - 4'd1;
      end
   end

   assign w_step_zero = (w_step_units == 4'd0) && (w_step_tens == 4'd0);

   always_comb begin
      w_state_nx = r_state;
      w_units_nx = r_units;
      w_tens_nx  = r_tens;
      w_presc_nx = r_presc;
      w_done_nx  = 1'b0;
      w_error_nx = 1'b0;
`ifdef COUNT_DOWN_AUTORELOAD_EN
      w_reload_nx = r_reload;
`endif
      if (start) begin
         if (w_ld_bad) begin
            w_error_nx = 1'b1;
            w_state_nx = ST_IDLE;
         end else if (w_ld_zero) begin
            w_units_nx = 4'd0;
            w_tens_nx  = 4'd0;
            w_presc_nx = 8'd0;
            w_done_nx  = 1'b1;
`ifdef COUNT_DOWN_AUTORELOAD_EN
            w_state_nx = ST_IDLE;
`else
            w_state_nx = ST_DONE;
`endif
         end else begin
            w_units_nx = load_value[3:0];
            w_tens_nx  = load_value[7:4];
            w_presc_nx = 8'd0;
            w_state_nx = ST_RUN;
`ifdef COUNT_DOWN_AUTORELOAD_EN
            w_reload_nx = load_value;
`endif
         end
      end else begin
         case (r_state)
            ST_RUN: begin
               if (pause) begin
                  w_state_nx = ST_PAUSED;
               end else if (r_presc == LP_LAST) begin
                  w_presc_nx = 8'd0;
                  w_units_nx = w_step_units;
                  w_tens_nx  = w_step_tens;
                  if (w_step_zero) begin
                     w_done_nx = 1'b1;
`ifndef COUNT_DOWN_AUTORELOAD_EN
                     w_state_nx = ST_DONE;
`endif
                  end
               end else begin
                  w_presc_nx = r_presc + 8'd1;
               end
            end
            ST_PAUSED: if (!pause) w_state_nx = ST_RUN;
            ST_DONE:   w_state_nx = ST_IDLE;
            default:   w_state_nx = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_units <= 4'd0;
         r_tens  <= 4'd0;
         r_presc <= 8'd0;
         r_done  <= 1'b0;
         r_error <= 1'b0;
`ifdef COUNT_DOWN_AUTORELOAD_EN
         r_reload <= 8'd0;
`endif
      end else begin
         r_state <= w_state_nx;
         r_units <= w_units_nx;
         r_tens  <= w_tens_nx;
         r_presc <= w_presc_nx;
         r_done  <= w_done_nx;
         r_error <= w_error_nx;
`ifdef COUNT_DOWN_AUTORELOAD_EN
         r_reload <= w_reload_nx;
`endif
      end
   end

   assign counter_value = r_units;
   assign tens_value    = r_tens;
   assign busy          = (r_state == ST_RUN) || (r_state == ST_PAUSED);
   assign done          = r_done;
   assign error         = r_error;
   assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_count_down_m100.sv
// Bench for count_down_m100: vector table plus hand-written pause, prescaler
// and asynchronous-reset sequences, checked through an expected-value queue.
module tb_count_down_m100;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0, pause = 1'b0;
   logic [7:0] load_value = 8'h00;
   logic [3:0] counter_value, tens_value;
   logic       busy, done, error;
   logic [1:0] dbg_state;

   logic       start3 = 1'b0, pause3 = 1'b0;
   logic [7:0] load3 = 8'h00;
   logic [3:0] units3, tens3;
   logic       busy3, done3, error3;
   logic [1:0] dbg_state3;

   count_down_m100 dut (
      .clk(clk), .rst(rst), .start(start), .pause(pause), .load_value(load_value),
      .counter_value(counter_value), .tens_value(tens_value), .busy(busy),
      .done(done), .error(error), .o_dbg_state(dbg_state)
   );

   count_down_m100 #(.STEP_DIV(3)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .pause(pause3), .load_value(load3),
      .counter_value(units3), .tens_value(tens3), .busy(busy3),
      .done(done3), .error(error3), .o_dbg_state(dbg_state3)
   );

   always #5 clk = ~clk;

   // Packed result layout: {tens, units, busy, done, error}
   localparam int W = 11;
   logic [W-1:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic       s;
      logic       p;
      logic [7:0] lv;
      logic [W-1:0] exp;
   } vec_t;
   vec_t vecs[$];

   function automatic logic [W-1:0] e(input logic [3:0] t, input logic [3:0] u,
                                      input logic b, input logic d, input logic er);
      return {t, u, b, d, er};
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got tens=%0h units=%0h busy=%b done=%b error=%b, want tens=%0h units=%0h busy=%b done=%b error=%b",
                    name, act[10:7], act[6:3], act[2], act[1], act[0],
                    exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
   endtask

   task automatic drive(input logic s, input logic p, input logic [7:0] lv,
                        input logic [W-1:0] exp, input string name);
      start = s; pause = p; load_value = lv;
      exp_q.push_back(exp);
      @(posedge clk); #1;
      chk(name, {tens_value, counter_value, busy, done, error}, exp_q.pop_front());
   endtask

   task automatic drive3(input logic s, input logic p, input logic [7:0] lv,
                         input logic [W-1:0] exp, input string name);
      start3 = s; pause3 = p; load3 = lv;
      exp_q.push_back(exp);
      @(posedge clk); #1;
      chk(name, {tens3, units3, busy3, done3, error3}, exp_q.pop_front());
   endtask

   task automatic add(input logic s, input logic p, input logic [7:0] lv, input logic [W-1:0] exp);
      vec_t v;
      v.s = s; v.p = p; v.lv = lv; v.exp = exp;
      vecs.push_back(v);
   endtask

   initial begin
      // Vector table
`ifdef COUNT_DOWN_AUTORELOAD_EN
      add(1, 0, 8'h03, e(0, 3, 1, 0, 0));
      add(0, 0, 8'h00, e(0, 2, 1, 0, 0));
      add(0, 0, 8'h00, e(0, 1, 1, 0, 0));
      add(0, 0, 8'h00, e(0, 0, 1, 1, 0));
      add(0, 0, 8'h00, e(0, 3, 1, 0, 0));
      add(0, 0, 8'h00, e(0, 2, 1, 0, 0));
      add(0, 0, 8'h00, e(0, 1, 1, 0, 0));
      add(0, 0, 8'h00, e(0, 0, 1, 1, 0));
      add(0, 0, 8'h00, e(0, 3, 1, 0, 0));
      add(1, 0, 8'h1A, e(0, 3, 0, 0, 1));
      add(0, 0, 8'h00, e(0, 3, 0, 0, 0));
`else
      add(1, 0, 8'h12, e(1, 2, 1, 0, 0));
      add(0, 0, 8'h00, e(1, 1, 1, 0, 0));
      add(0, 0, 8'h00, e(1, 0, 1, 0, 0));
      add(0, 0, 8'h00, e(0, 9, 1, 0, 0));
      add(0, 0, 8'h00, e(0, 8, 1, 0, 0));
      add(0, 0, 8'h00, e(0, 7, 1, 0, 0));
      add(0, 0, 8'h00, e(0, 6, 1, 0, 0));
      add(0, 0, 8'h00, e(0, 5, 1, 0, 0));
      add(0, 0, 8'h00, e(0, 4, 1, 0, 0));
      add(0, 0, 8'h00, e(0, 3, 1, 0, 0));
      add(0, 0, 8'h00, e(0, 2, 1, 0, 0));
      add(0, 0, 8'h00, e(0, 1, 1, 0, 0));
      add(0, 0, 8'h00, e(0, 0, 0, 1, 0));
      add(0, 0, 8'h00, e(0, 0, 0, 0, 0));
      add(1, 0, 8'h1A, e(0, 0, 0, 0, 1));
      add(0, 0, 8'h00, e(0, 0, 0, 0, 0));
`endif
      add(1, 0, 8'h00, e(0, 0, 0, 1, 0));
      add(0, 0, 8'h00, e(0, 0, 0, 0, 0));
      add(1, 1, 8'h25, e(2, 5, 1, 0, 0));
      add(0, 1, 8'h00, e(2, 5, 1, 0, 0));
      add(0, 0, 8'h00, e(2, 5, 1, 0, 0));
      add(0, 0, 8'h00, e(2, 4, 1, 0, 0));
      add(1, 0, 8'h30, e(3, 0, 1, 0, 0));
      add(0, 0, 8'h00, e(2, 9, 1, 0, 0));
      add(1, 0, 8'h3F, e(2, 9, 0, 0, 1));
      add(0, 0, 8'h00, e(2, 9, 0, 0, 0));
      add(1, 0, 8'hA1, e(2, 9, 0, 0, 1));
      add(0, 0, 8'h00, e(2, 9, 0, 0, 0));

      // Reset state, then release between edges
      #12;
      chk("reset_state", {tens_value, counter_value, busy, done, error}, '0);
      chk("reset_state3", {tens3, units3, busy3, done3, error3}, '0);
      #10 rst = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < vecs.size(); i++)
         drive(vecs[i].s, vecs[i].p, vecs[i].lv, vecs[i].exp, $sformatf("vec[%0d]", i));

      // Pause at 0/5 for three cycles
      drive(1, 0, 8'h07, e(0, 7, 1, 0, 0), "pause_load");
      drive(0, 0, 8'h00, e(0, 6, 1, 0, 0), "pause_pre6");
      drive(0, 0, 8'h00, e(0, 5, 1, 0, 0), "pause_pre5");
      for (int i = 0; i < 3; i++)
         drive(0, 1, 8'h00, e(0, 5, 1, 0, 0), $sformatf("pause_hold%0d", i));
      drive(0, 0, 8'h00, e(0, 5, 1, 0, 0), "pause_resume");
      drive(0, 0, 8'h00, e(0, 4, 1, 0, 0), "pause_step");

      // STEP_DIV=3: first step three edges after load, prescaler frozen in pause
      drive3(1, 0, 8'h05, e(0, 5, 1, 0, 0), "div3_load");
      drive3(0, 0, 8'h00, e(0, 5, 1, 0, 0), "div3_e1");
      drive3(0, 0, 8'h00, e(0, 5, 1, 0, 0), "div3_e2");
      drive3(0, 0, 8'h00, e(0, 4, 1, 0, 0), "div3_e3");
      drive3(0, 0, 8'h00, e(0, 4, 1, 0, 0), "div3_e4");
      drive3(0, 1, 8'h00, e(0, 4, 1, 0, 0), "div3_pause1");
      drive3(0, 1, 8'h00, e(0, 4, 1, 0, 0), "div3_pause2");
      drive3(0, 0, 8'h00, e(0, 4, 1, 0, 0), "div3_resume");
      drive3(0, 0, 8'h00, e(0, 4, 1, 0, 0), "div3_e8");
      drive3(0, 0, 8'h00, e(0, 3, 1, 0, 0), "div3_e9");

      // Asynchronous reset mid-count at 0/7
      drive(1, 0, 8'h09, e(0, 9, 1, 0, 0), "rst_load");
      drive(0, 0, 8'h00, e(0, 8, 1, 0, 0), "rst_pre8");
      drive(0, 0, 8'h00, e(0, 7, 1, 0, 0), "rst_pre7");
      #2 rst = 1'b0;
      #1;
      chk("rst_async", {tens_value, counter_value, busy, done, error}, '0);
      chk("rst_async3", {tens3, units3, busy3, done3, error3}, '0);
      @(posedge clk); #1;
      chk("rst_held", {tens_value, counter_value, busy, done, error}, '0);
      #3 rst = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_idle", {tens_value, counter_value, busy, done, error}, '0);
      drive(1, 0, 8'h02, e(0, 2, 1, 0, 0), "post_rst_load");
      drive(0, 0, 8'h00, e(0, 1, 1, 0, 0), "post_rst_step");

      start = 1'b0; pause = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
